// File: rtl/axis_depacketizer_pkg.sv
// Shared types for the AXI-Stream depacketizer: the frame-tracking FSM states.
package axis_depacketizer_pkg;

  typedef enum logic [1:0] {
    ST_PASS,
    ST_PAD,
    ST_DROP
  } depkt_state_t;

endpackage

// File: rtl/axis_depacketizer_if.sv
// AXI-Stream bundle used on both sides of the depacketizer.
// A beat transfers on a rising aclk edge where tvalid && tready; once tvalid is raised the
// master holds tdata/tlast/tuser stable and keeps tvalid high until that edge.
interface axis_depacketizer_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  // The input side is framed by tlast; the output side is unframed and marks frame starts in tuser.
  modport master (
    output tdata,
    output tvalid,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_depacketizer_frame_beat_counter.sv
// Beat position within the current frame plus the latched last-beat index.
// at_last uses the live frame_length while a new frame is being opened so the first beat compares correctly.
module frame_beat_counter #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COUNTER_WIDTH-1:0] frame_length,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     clr,
  output logic [COUNTER_WIDTH-1:0] idx,
  output logic                     at_last
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] last_idx;
  logic [COUNTER_WIDTH-1:0] eff_last;

  // frame_length of 0 wraps to all-ones, i.e. 2^COUNTER_WIDTH beats.
  assign eff_last = load ? (frame_length - CNT_ONE) : last_idx;
  assign at_last  = (idx == eff_last);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx      <= '0;
      last_idx <= '0;
    end else begin
      if (load) begin
        last_idx <= frame_length - CNT_ONE;
      end
      if (clr) begin
        idx <= '0;
      end else if (inc) begin
        idx <= idx + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/axis_depacketizer.sv
// Receive-side depacketizer: forces every frame to frame_length beats (pad short, truncate long)
// and emits an unframed stream with a start-of-frame tuser marker plus per-frame status.
module axis_depacketizer
  import axis_depacketizer_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    COUNTER_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COUNTER_WIDTH-1:0] frame_length,
  axis_depacketizer_if.slave       s_axis,
  axis_depacketizer_if.master      m_axis,
  output logic                     frame_done,
  output logic                     short_err,
  output logic                     long_err,
  output logic [COUNTER_WIDTH-1:0] short_count,
  output logic [COUNTER_WIDTH-1:0] long_count,
  output depkt_state_t             dbg_state
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  depkt_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]    tdata_q;
  logic                     tvalid_q;
  logic                     tuser_q;
  logic                     out_en;
  logic                     s_ready;
  logic                     load_out;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_user;
  logic                     done_c;
  logic                     short_c;
  logic                     long_c;
  logic                     cnt_load;
  logic                     cnt_inc;
  logic                     cnt_clr;
  logic [COUNTER_WIDTH-1:0] idx;
  logic                     at_last;

  frame_beat_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_beat_counter (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .frame_length (frame_length),
    .load         (cnt_load),
    .inc          (cnt_inc),
    .clr          (cnt_clr),
    .idx          (idx),
    .at_last      (at_last)
  );

  // The output register can take a new beat when it is empty or being drained this cycle.
  assign out_en = !tvalid_q || m_axis.tready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load_out  = 1'b0;
    out_data  = s_axis.tdata;
    out_user  = 1'b0;
    done_c    = 1'b0;
    short_c   = 1'b0;
    long_c    = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_PASS: begin
        s_ready  = out_en;
        cnt_load = (idx == '0);
        if (s_axis.tvalid && out_en) begin
          load_out = 1'b1;
          out_user = (idx == '0);
          if (s_axis.tlast && at_last) begin
            done_c  = 1'b1;
            cnt_clr = 1'b1;
          end else if (s_axis.tlast) begin
            short_c   = 1'b1;
            cnt_inc   = 1'b1;
            state_nxt = ST_PAD;
          end else if (at_last) begin
            // Frame is full but the sender keeps going: close it here and discard the rest.
            long_c    = 1'b1;
            done_c    = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ST_DROP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (out_en) begin
          load_out = 1'b1;
          out_data = PAD_VALUE;
          if (at_last) begin
            done_c    = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ST_PASS;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          state_nxt = ST_PASS;
        end
      end
      default: state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_PASS;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      frame_done  <= 1'b0;
      short_err   <= 1'b0;
      long_err    <= 1'b0;
      short_count <= '0;
      long_count  <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_c;
      short_err  <= short_c;
      long_err   <= long_c;
      if (load_out) begin
        tdata_q  <= out_data;
        tuser_q  <= out_user;
        tvalid_q <= 1'b1;
      end else if (m_axis.tready) begin
        tvalid_q <= 1'b0;
      end
      if (short_c && (short_count != '1)) begin
        short_count <= short_count + CNT_ONE;
      end
      if (long_c && (long_count != '1)) begin
        long_count <= long_count + CNT_ONE;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tuser  = tuser_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_axis_depacketizer.sv
// Bench for axis_depacketizer: frame-level model feeds an expected-beat queue checked at the output.
module tb_axis_depacketizer;
  import axis_depacketizer_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam logic [DW-1:0] PAD = 16'hA5A5;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] frame_length = CW'(4);
  logic          frame_done;
  logic          short_err;
  logic          long_err;
  logic [CW-1:0] short_count;
  logic [CW-1:0] long_count;
  depkt_state_t  dbg_state;

  axis_depacketizer_if #(.DATA_WIDTH(DW)) s_axis ();
  axis_depacketizer_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_depacketizer #(
    .DATA_WIDTH    (DW),
    .COUNTER_WIDTH (CW),
    .PAD_VALUE     (PAD)
  ) u_dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .frame_length (frame_length),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .frame_done   (frame_done),
    .short_err    (short_err),
    .long_err     (long_err),
    .short_count  (short_count),
    .long_count   (long_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  logic [DW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_done, exp_short, exp_long;
  int done_seen, short_seen, long_seen;
  int stall_cycles;
  bit rand_ready = 1'b0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_user = 1'b0;
  logic [DW:0]   exp_beat;

  task automatic do_reset();
    aresetn = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    exp_done = 0; exp_short = 0; exp_long = 0;
    done_seen = 0; short_seen = 0; long_seen = 0;
    stall_cycles = 0;
  endtask

  // ---------------- output ready driver ----------------
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (frame_done) done_seen++;
        if (short_err) short_seen++;
        if (long_err) long_seen++;
        if (prev_stall) begin
          checks++;
          if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== prev_data || m_axis.tuser !== prev_user) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h user=%b, required valid=1 data=%h user=%b",
                     m_axis.tvalid, m_axis.tdata, m_axis.tuser, prev_data, prev_user);
          end
        end
        if (m_axis.tvalid && m_axis.tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_beat: got unexpected beat user=%b data=%h, required no beat", m_axis.tuser, m_axis.tdata);
          end else begin
            exp_beat = exp_q.pop_front();
            if ({m_axis.tuser, m_axis.tdata} !== exp_beat) begin
              errors++;
              $display("FAIL out_beat: got user=%b data=%h, required user=%b data=%h",
                       m_axis.tuser, m_axis.tdata, exp_beat[DW], exp_beat[DW-1:0]);
            end
          end
        end
      end
      prev_stall = aresetn && m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      prev_user  = m_axis.tuser;
    end
  end

  // ---------------- input driver + frame model ----------------
  task automatic send_frame(input int n, input int len);
    logic [DW-1:0] beats[$];
    logic rdy;
    int w;
    for (int i = 0; i < n; i++) begin
      beats.push_back(DW'($urandom_range(0, 65535)));
      if (i < len) exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, beats[i]});
    end
    for (int i = n; i < len; i++) exp_q.push_back({1'b0, PAD});
    if (n < len) exp_short++;
    if (n > len) exp_long++;
    exp_done++;
    for (int i = 0; i < n; i++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata = beats[i];
      s_axis.tlast = (i == n - 1);
      w = 0;
      do begin
        @(negedge aclk);
        rdy = s_axis.tready;
        @(posedge aclk);
        #1;
        if (!rdy) begin
          stall_cycles++;
          w++;
        end
      end while (!rdy && w < 200);
      if (!rdy) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat %0d still not accepted after %0d cycles, required acceptance", i, w);
        break;
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
  endtask

  task automatic drain_output();
    int w;
    rand_ready = 1'b0;
    w = 0;
    while ((exp_q.size() != 0 || m_axis.tvalid) && w < 300) begin
      @(posedge aclk);
      #1;
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats still missing, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    s_axis.tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks += 9;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis.tvalid); end
    if (m_axis.tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b required 0", m_axis.tuser); end
    if (m_axis.tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h required 0", m_axis.tdata); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    if (short_err !== 1'b0) begin errors++; $display("FAIL rst_short_err: got %b required 0", short_err); end
    if (long_err !== 1'b0) begin errors++; $display("FAIL rst_long_err: got %b required 0", long_err); end
    if (short_count !== '0) begin errors++; $display("FAIL rst_short_count: got %0d required 0", short_count); end
    if (long_count !== '0) begin errors++; $display("FAIL rst_long_count: got %0d required 0", long_count); end
    if (dbg_state !== ST_PASS) begin errors++; $display("FAIL rst_state: got %0d required %0d", dbg_state, ST_PASS); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d[4];
    do_reset();
    frame_length = CW'(4);
    for (int i = 0; i < 4; i++) begin
      d[i] = DW'($urandom_range(0, 65535));
      exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, d[i]});
    end
    exp_done++;
    for (int i = 0; i < 4; i++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata = d[i];
      s_axis.tlast = (i == 3);
      @(posedge aclk);
      #1;
      checks++;
      if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== d[i] || m_axis.tuser !== (i == 0)) begin
        errors++;
        $display("FAIL basic_latency: beat %0d got valid=%b data=%h user=%b, required valid=1 data=%h user=%b",
                 i, m_axis.tvalid, m_axis.tdata, m_axis.tuser, d[i], (i == 0));
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_done_align: got %b required 1", frame_done); end
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    send_frame(4, 4);
    drain_output();
    checks += 4;
    if (done_seen != exp_done) begin errors++; $display("FAIL basic_done: got %0d required %0d", done_seen, exp_done); end
    if (short_seen != 0) begin errors++; $display("FAIL basic_short: got %0d required 0", short_seen); end
    if (long_seen != 0) begin errors++; $display("FAIL basic_long: got %0d required 0", long_seen); end
    if (stall_cycles != 0) begin errors++; $display("FAIL basic_stall: got %0d required 0", stall_cycles); end
  endtask

  task automatic test_short_pad();
    do_reset();
    frame_length = CW'(4);
    send_frame(2, 4);
    send_frame(4, 4);
    drain_output();
    checks += 5;
    if (stall_cycles != 2) begin errors++; $display("FAIL pad_ready_low: got %0d cycles required 2", stall_cycles); end
    if (short_seen != 1) begin errors++; $display("FAIL pad_short_err: got %0d required 1", short_seen); end
    if (short_count !== CW'(1)) begin errors++; $display("FAIL pad_short_count: got %0d required 1", short_count); end
    if (long_seen != 0) begin errors++; $display("FAIL pad_long_err: got %0d required 0", long_seen); end
    if (done_seen != 2) begin errors++; $display("FAIL pad_done: got %0d required 2", done_seen); end
  endtask

  task automatic test_long_drop();
    do_reset();
    frame_length = CW'(4);
    send_frame(6, 4);
    send_frame(4, 4);
    drain_output();
    checks += 5;
    if (stall_cycles != 0) begin errors++; $display("FAIL drop_stall: got %0d required 0", stall_cycles); end
    if (long_seen != 1) begin errors++; $display("FAIL drop_long_err: got %0d required 1", long_seen); end
    if (long_count !== CW'(1)) begin errors++; $display("FAIL drop_long_count: got %0d required 1", long_count); end
    if (short_seen != 0) begin errors++; $display("FAIL drop_short_err: got %0d required 0", short_seen); end
    if (done_seen != 2) begin errors++; $display("FAIL drop_done: got %0d required 2", done_seen); end
  endtask

  task automatic test_random_stall();
    do_reset();
    frame_length = CW'(3);
    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 5), 3);
    drain_output();
    checks += 5;
    if (done_seen != exp_done) begin errors++; $display("FAIL rand_done: got %0d required %0d", done_seen, exp_done); end
    if (short_seen != exp_short) begin errors++; $display("FAIL rand_short_err: got %0d required %0d", short_seen, exp_short); end
    if (long_seen != exp_long) begin errors++; $display("FAIL rand_long_err: got %0d required %0d", long_seen, exp_long); end
    if (short_count !== CW'(exp_short)) begin errors++; $display("FAIL rand_short_count: got %0d required %0d", short_count, exp_short); end
    if (long_count !== CW'(exp_long)) begin errors++; $display("FAIL rand_long_count: got %0d required %0d", long_count, exp_long); end
  endtask

  task automatic test_len_one();
    do_reset();
    frame_length = CW'(1);
    send_frame(1, 1);
    for (int f = 0; f < 3; f++) send_frame(2, 1);
    drain_output();
    checks += 4;
    if (long_seen != 3) begin errors++; $display("FAIL len1_long_err: got %0d required 3", long_seen); end
    if (long_count !== CW'(3)) begin errors++; $display("FAIL len1_long_count: got %0d required 3", long_count); end
    if (done_seen != 4) begin errors++; $display("FAIL len1_done: got %0d required 4", done_seen); end
    if (stall_cycles != 0) begin errors++; $display("FAIL len1_stall: got %0d required 0", stall_cycles); end
  endtask

  task automatic test_reset_in_pad();
    logic [DW-1:0] d0, d1;
    do_reset();
    frame_length = CW'(4);
    d0 = DW'($urandom_range(0, 65535));
    d1 = DW'($urandom_range(0, 65535));
    exp_q.push_back({1'b1, d0});
    s_axis.tvalid = 1'b1; s_axis.tdata = d0; s_axis.tlast = 1'b0;
    @(posedge aclk); #1;
    s_axis.tdata = d1; s_axis.tlast = 1'b1;
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    checks++;
    if (dbg_state !== ST_PAD) begin errors++; $display("FAIL rpad_in_pad: got state %0d required %0d", dbg_state, ST_PAD); end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    checks += 6;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL rpad_tvalid: got %b required 0", m_axis.tvalid); end
    if (m_axis.tdata !== '0 || m_axis.tuser !== 1'b0) begin errors++; $display("FAIL rpad_tdata: got %h/%b required 0/0", m_axis.tdata, m_axis.tuser); end
    if (frame_done !== 1'b0 || short_err !== 1'b0 || long_err !== 1'b0) begin errors++; $display("FAIL rpad_pulses: got %b%b%b required 000", frame_done, short_err, long_err); end
    if (short_count !== '0 || long_count !== '0) begin errors++; $display("FAIL rpad_counts: got %0d/%0d required 0/0", short_count, long_count); end
    if (dbg_state !== ST_PASS) begin errors++; $display("FAIL rpad_state: got %0d required %0d", dbg_state, ST_PASS); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL rpad_first_beat: got %0d beats undelivered required 0", exp_q.size()); end
    aresetn = 1'b1;
    exp_q.delete();
    send_frame(4, 4);
    drain_output();
    checks += 2;
    if (done_seen != 1) begin errors++; $display("FAIL rpad_done: got %0d required 1", done_seen); end
    if (short_seen != 0) begin errors++; $display("FAIL rpad_short: got %0d required 0", short_seen); end
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    s_axis.tdata = '0;
    s_axis.tuser = 1'b0;
    m_axis.tlast = 1'b0;
    test_reset();
    test_basic();
    test_short_pad();
    test_long_drop();
    test_random_stall();
    test_len_one();
    test_reset_in_pad();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
